uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Memory-mapped UART receive front end that sits directly upstream of the system bridge's read path. It deserialises 8N1 frames from `uart_rxd` and buffers the bytes in a small FIFO. The CPU drains the FIFO through word-addressed registers and reads status and error flags. A level interrupt goes to the CPU hardware interrupt vector while data is pending.

## Interface
Parameters:
- `CLK_FREQ`, 25_000_000: clock frequency in Hz.
- `BAUD`, 9600: line rate. `DIV = CLK_FREQ/BAUD` uses integer truncation and must be at least 4.
- `DEPTH`, 8: FIFO entries. Must be a power of two, at least 2.

Ports:
- `clk`, input, 1: system clock.
- `reset`, input, 1: asynchronous, active-low reset.
- `uart_rxd`, input, 1: serial line, idle high, asynchronous to `clk`.
- `rd`, input, 1: bus read strobe, one cycle per access.
- `we`, input, 1: bus write strobe, one cycle per access.
- `addr`, input, 2: word offset. 0 = DATA, 1 = STATUS, 2 = CTRL, 3 = reserved.
- `wdata`, input, 32: write data.
- `rdata`, output, 32: registered read data.
- `irq`, output, 1: interrupt request, level, active-high.

## Operation
- **Input synchroniser:** `uart_rxd` passes through a 2-flop synchroniser, which resets to 1. All FSM decisions use the synchronised value `rxs`.
- **FSM states:**
  - IDLE: on `rxs==0`, clear the baud counter and go to START.
  - START: count `DIV/2` cycles, then sample. If `rxs==0`, go to DATA with bit index 0. If `rxs==1`, the start was a glitch; return to IDLE.
  - DATA: every `DIV` cycles, sample into shift bit `[idx]`, LSB first. After bit 7, go to STOP.
  - STOP: after `DIV` cycles, sample. If 1, push the byte and go to IDLE. If 0, set `ferr`, discard the byte, and go to BREAK.
  - BREAK: wait for `rxs==1`, then go to IDLE. This stops a held-low line from re-triggering frames.
- **FIFO:** `log2(DEPTH)`-bit read and write pointers that wrap modulo `DEPTH`, plus a `log2(DEPTH)+1`-bit `count`.
  - Push when full: the byte is dropped, `ovr` is set, and FIFO contents are unchanged.
  - Pop when empty: no state change.
  - Push and pop in the same cycle: both take effect and `count` is unchanged. This holds when full, since the pop frees a slot. When empty, only the push takes effect.
- **Registers:**
  - DATA (read): `{24'b0, head byte}` and pops one entry. When empty, returns 0. Writes to DATA are ignored.
  - STATUS (read): `{16'b0, count[7:0], 4'b0, ovr, ferr, full, empty}`. Reading has no side effect. Writing clears `ovr` where `wdata[3]=1` and clears `ferr` where `wdata[2]=1`.
  - CTRL (read/write): bit 0 is `ien`. Other bits read as 0.
  - Reserved offset 3: reads 0, writes are ignored.
- **Strobe conflicts:** `rd` and `we` together in one cycle means the write is performed and the read is ignored. `rdata` holds its previous value.
- **Flag set vs. clear:** a flag set by the receiver in the same cycle as a software clear remains set.
- **Interrupt:** `irq = ien & ~empty`, registered.

## Timing
- **Reset values:** `rdata=0`, `irq=0`. Internally: FSM=IDLE, pointers=0, `count=0`, `ovr=0`, `ferr=0`, `ien=0`, synchroniser=1. Reset takes effect immediately and asynchronously, including mid-frame; the partial byte is lost. Release is sampled on the next `clk` edge.
- **Read latency:** `rd` sampled at edge N puts `rdata` valid after edge N and holds it until the next `rd`. For a DATA read, the pop and the updated `count`/`empty` also take effect at edge N.
- **Push timing:** the push occurs on the cycle the stop bit is sampled. This is about 2 cycles (synchroniser) + `DIV/2` + 9·`DIV` after the start-bit falling edge.
- **`irq` timing:** `irq` rises one cycle after `count` goes from 0 to 1. It falls one cycle after the pop that empties the FIFO.
- **Throughput:** back-to-back frames are received without loss. IDLE re-arms within 1 cycle after the stop-bit sample.

## Test plan
Use `CLK_FREQ=16`, `BAUD=1` (DIV=16) and `DEPTH=4`.
- **Single byte:** after reset, write CTRL=1, then send frame 0xA5. Then `irq=1` and STATUS=`0x00000100`. A DATA read returns `0x000000A5`, and `irq` falls the following cycle.
- **Overrun and wrap:** send 0x01..0x05 with no reads. Then STATUS=`0x0000040A` (count 4, `ovr`, full). Four DATA reads return 1, 2, 3, 4. A further read returns 0. Write STATUS=8; then STATUS=`0x00000001`.
- **Framing error and break:** send 0x3C with stop bit = 0, then hold the line low for 40 cycles. Result: `ferr=1`, no push, the FSM stays in BREAK. After the line returns high, 0x55 is received correctly.
- **Glitch rejection:** a 3-cycle low pulse on `uart_rxd` produces no push and no `ferr`.
- **Simultaneous push/pop:** FIFO is full. A DATA read in the same cycle as a stop-bit push gives `count=4`, no `ovr`, and the new byte is last in order.
- **Mid-frame reset:** assert `reset` low during bit 4 of a frame. All outputs are 0 immediately. After release, the next frame 0x7E is received intact.

Source files
------------

// File: rtl/uart_rx_fifo_if.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo_if
//
// Word-addressed register bus between a CPU-side bridge and the UART receive
// front end.
//
// Signals:
//   rd     - read strobe, one cycle per access
//   we     - write strobe, one cycle per access
//   addr   - word offset (0 DATA, 1 STATUS, 2 CTRL, 3 reserved)
//   wdata  - write data
//   rdata  - registered read data, driven by the peripheral
//
// Modports:
//   master - the bus side that issues accesses
//   slave  - the peripheral side that answers them
// ---------------------------------------------------------------------------
interface uart_rx_fifo_if;
    logic        rd;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output rd, output we, output addr, output wdata, input rdata);
    modport slave  (input rd, input we, input addr, input wdata, output rdata);
endinterface

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
//
// UART receive front end. Deserialises 8N1 frames from uart_rxd, buffers the
// received bytes in a small FIFO and exposes them to the CPU through three
// word-addressed registers. A registered level interrupt is raised while
// the interrupt enable is set and data is waiting.
//
// Parameters:
//   CLK_FREQ - clock frequency in Hz
//   BAUD     - line rate; DIV = CLK_FREQ/BAUD (truncated), at least 4
//   DEPTH    - FIFO entries, power of two, at least 2
//
// Ports:
//   clk      - system clock
//   reset    - asynchronous reset, active low
//   uart_rxd - serial input, idle high, asynchronous to clk
//   bus      - register bus (slave side): rd, we, addr, wdata, rdata
//   irq      - interrupt request, level, active high, registered
//
// Register map (word offsets):
//   0 DATA   R : {24'b0, head byte}, pops one entry; 0 when empty
//   1 STATUS R : {16'b0, count[7:0], 4'b0, ovr, ferr, full, empty}
//            W : wdata[3]=1 clears ovr, wdata[2]=1 clears ferr
//   2 CTRL   RW: bit 0 = ien
//   3 reserved, reads 0
// ---------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter int CLK_FREQ = 25_000_000,
    parameter int BAUD     = 9600,
    parameter int DEPTH    = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          uart_rxd,
    uart_rx_fifo_if.slave bus,
    output logic          irq
);

    localparam int DIV  = CLK_FREQ / BAUD;
    localparam int HALF = DIV / 2;
    localparam int CW   = $clog2(DIV);
    localparam int AW   = $clog2(DEPTH);

    localparam logic [CW-1:0] DIV_LAST   = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_LAST  = CW'(HALF - 1);
    localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BRK
    } rx_state_e;

    // Synchroniser and receiver state
    logic            sync1_q;
    logic            rxs_q;
    rx_state_e       state_q, state_d;
    logic [CW-1:0]   baud_q, baud_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            push_req;
    logic            ferr_set;

    // FIFO storage and bookkeeping
    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   wptr_q, rptr_q;
    logic [AW:0]     count_q, count_d;
    logic            empty;
    logic            full;
    logic            pop;
    logic            push_ok;
    logic            ovr_set;
    logic [7:0]      count8;

    // Register-side state
    logic            ovr_q, ovr_d;
    logic            ferr_q, ferr_d;
    logic            ien_q, ien_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            irq_q;
    logic            rd_acc;
    logic            status_wr;
    logic            ctrl_wr;

    // Only wdata bits 0, 2 and 3 carry meaning; the rest are intentionally
    // ignored.
    logic            unused_wdata;
    assign unused_wdata = ^{bus.wdata[31:4], bus.wdata[1]};

    // Two-flop synchroniser; idles high so reset never looks like a start bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b1;
            rxs_q   <= 1'b1;
        end else begin
            sync1_q <= uart_rxd;
            rxs_q   <= sync1_q;
        end
    end

    // Receiver state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            idx_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
        end
    end

    // Receiver next state. START waits half a bit so every later sample
    // lands mid-bit; BRK holds off re-arming until the line returns high so a
    // stuck-low line cannot generate a stream of bogus frames.
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        push_req = 1'b0;
        ferr_set = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!rxs_q) begin
                    baud_d  = '0;
                    state_d = START;
                end
            end
            START: begin
                if (baud_q == HALF_LAST) begin
                    baud_d = '0;
                    if (!rxs_q) begin
                        idx_d   = '0;
                        state_d = DATA;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (baud_q == DIV_LAST) begin
                    baud_d         = '0;
                    shift_d[idx_q] = rxs_q;
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            STOP: begin
                if (baud_q == DIV_LAST) begin
                    baud_d = '0;
                    if (rxs_q) begin
                        push_req = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        ferr_set = 1'b1;
                        state_d  = BRK;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            BRK: begin
                if (rxs_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Bus decode. A simultaneous read and write performs only the write.
    assign rd_acc    = bus.rd & ~bus.we;
    assign status_wr = bus.we & (bus.addr == 2'd1);
    assign ctrl_wr   = bus.we & (bus.addr == 2'd2);

    // FIFO control. A pop in the same cycle frees the slot a push into a full
    // FIFO needs, so only a push without a pop overruns.
    assign empty   = (count_q == '0);
    assign full    = (count_q == FULL_COUNT);
    assign pop     = rd_acc & (bus.addr == 2'd0) & ~empty;
    assign push_ok = push_req & (~full | pop);
    assign ovr_set = push_req & full & ~pop;
    assign count8  = 8'(count_q);

    always_comb begin
        count_d = count_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // FIFO storage has no reset; only slots below count are ever read.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wptr_q] <= shift_q;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    // Sticky flags, enable and read data. Software clears are applied first
    // so a receiver event in the same cycle wins.
    always_comb begin
        ovr_d   = ovr_q;
        ferr_d  = ferr_q;
        ien_d   = ien_q;
        rdata_d = rdata_q;

        if (status_wr && bus.wdata[3]) begin
            ovr_d = 1'b0;
        end
        if (status_wr && bus.wdata[2]) begin
            ferr_d = 1'b0;
        end
        if (ovr_set) begin
            ovr_d = 1'b1;
        end
        if (ferr_set) begin
            ferr_d = 1'b1;
        end
        if (ctrl_wr) begin
            ien_d = bus.wdata[0];
        end

        if (rd_acc) begin
            case (bus.addr)
                2'd0:    rdata_d = empty ? 32'h0 : {24'h0, mem[rptr_q]};
                2'd1:    rdata_d = {16'h0, count8, 4'h0, ovr_q, ferr_q, full, empty};
                2'd2:    rdata_d = {31'h0, ien_q};
                default: rdata_d = 32'h0;
            endcase
        end
    end

    // Register-side state, including the registered interrupt.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovr_q   <= 1'b0;
            ferr_q  <= 1'b0;
            ien_q   <= 1'b0;
            rdata_q <= 32'h0;
            irq_q   <= 1'b0;
        end else begin
            ovr_q   <= ovr_d;
            ferr_q  <= ferr_d;
            ien_q   <= ien_d;
            rdata_q <= rdata_d;
            irq_q   <= ien_q & ~empty;
        end
    end

    assign bus.rdata = rdata_q;
    assign irq       = irq_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_fifo
//
// Directed bench for uart_rx_fifo with DIV=16 and DEPTH=4. A queue-based
// model of the FIFO, flags and register map runs in one compare process that
// checks rdata and irq after every clock edge and immediately after reset
// assertion. Literal expected values posted by the stimulus are checked by
// the same process on the edge they refer to.
// ---------------------------------------------------------------------------
module tb_uart_rx_fifo;

    localparam int CLK_FREQ = 16;
    localparam int BAUD     = 1;
    localparam int DEPTH    = 4;
    localparam int DIV      = CLK_FREQ / BAUD;
    // Edges from the start-bit fall to the stop-bit sample: two synchroniser
    // stages, one edge to leave IDLE, half a bit, then nine whole bits.
    localparam int PUSH_EDGE = 3 + DIV / 2 + 9 * DIV;

    logic clk      = 1'b0;
    logic reset    = 1'b0;
    logic uart_rxd = 1'b1;
    logic irq;

    uart_rx_fifo_if bus ();

    uart_rx_fifo #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD),
        .DEPTH    (DEPTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .uart_rxd (uart_rxd),
        .bus      (bus.slave),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    // Frame and literal-expectation mailboxes written by the stimulus.
    int          frameSeq = 0;
    logic [7:0]  pendByte = 8'h0;
    logic        pendStop = 1'b1;
    int          pinSeq   = 0;
    int          pinKind  = 0;
    logic [31:0] pinVal   = 32'h0;
    string       pinName  = "";

    // Counters, written only by the compare process.
    int checks = 0;
    int errors = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model and per-cycle comparison.
    always begin : compareProc
        logic [7:0]  mq[$];
        logic        mOvr;
        logic        mFerr;
        logic        mIen;
        logic [31:0] mRdata;
        logic [31:0] irqE;
        int          cd;
        int          seenSeq;
        int          pinSeen;
        bit          mEmpty;
        bit          mFull;
        bit          doPop;

        @(posedge clk or negedge reset);
        #1;
        if (!reset) begin
            mq.delete();
            mOvr    = 1'b0;
            mFerr   = 1'b0;
            mIen    = 1'b0;
            mRdata  = 32'h0;
            cd      = 0;
            seenSeq = frameSeq;
            pinSeen = pinSeq;
            checkOutput("rdata_in_reset", bus.rdata, 32'h0);
            checkOutput("irq_in_reset", {31'h0, irq}, 32'h0);
        end else begin
            irqE   = {31'h0, mIen && (mq.size() != 0)};
            mEmpty = (mq.size() == 0);
            mFull  = (mq.size() == DEPTH);
            doPop  = 1'b0;

            if (bus.rd && !bus.we) begin
                case (bus.addr)
                    2'd0: begin
                        if (mEmpty) begin
                            mRdata = 32'h0;
                        end else begin
                            mRdata = {24'h0, mq[0]};
                            doPop  = 1'b1;
                        end
                    end
                    2'd1:    mRdata = {16'h0, 8'(mq.size()), 4'h0, mOvr, mFerr, mFull, mEmpty};
                    2'd2:    mRdata = {31'h0, mIen};
                    default: mRdata = 32'h0;
                endcase
            end

            if (bus.we && bus.addr == 2'd1) begin
                if (bus.wdata[3]) mOvr = 1'b0;
                if (bus.wdata[2]) mFerr = 1'b0;
            end
            if (bus.we && bus.addr == 2'd2) begin
                mIen = bus.wdata[0];
            end

            if (doPop) begin
                void'(mq.pop_front());
            end

            if (frameSeq != seenSeq) begin
                seenSeq = frameSeq;
                cd      = PUSH_EDGE - 1;
            end else if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    if (pendStop) begin
                        if (mq.size() < DEPTH) mq.push_back(pendByte);
                        else mOvr = 1'b1;
                    end else begin
                        mFerr = 1'b1;
                    end
                end
            end

            checkOutput("rdata_model", bus.rdata, mRdata);
            checkOutput("irq_model", {31'h0, irq}, irqE);

            if (pinSeq != pinSeen) begin
                pinSeen = pinSeq;
                if (pinKind == 0) checkOutput(pinName, bus.rdata, pinVal);
                else checkOutput(pinName, {31'h0, irq}, pinVal);
            end
        end
    end

    task automatic postPin(input int kind, input logic [31:0] val, input string name);
        pinKind = kind;
        pinVal  = val;
        pinName = name;
        pinSeq++;
    endtask

    task automatic busWrite(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.we    = 1'b1;
        bus.addr  = a;
        bus.wdata = d;
        @(negedge clk);
        bus.we    = 1'b0;
        bus.wdata = 32'h0;
    endtask

    task automatic busRead(input logic [1:0] a, input logic [31:0] exp, input string name);
        @(negedge clk);
        bus.rd   = 1'b1;
        bus.addr = a;
        postPin(0, exp, name);
        @(negedge clk);
        bus.rd = 1'b0;
    endtask

    task automatic expectIrq(input logic v, input string name);
        @(negedge clk);
        postPin(1, {31'h0, v}, name);
    endtask

    // Sends one frame; leaves the line at the stop-bit level. With rdAtStop
    // a DATA read is issued so it is sampled on the stop-bit sample edge.
    task automatic sendFrame(input logic [7:0] b, input logic stopBit,
                             input bit rdAtStop, input logic [31:0] popExp);
        @(negedge clk);
        pendByte = b;
        pendStop = stopBit;
        frameSeq++;
        uart_rxd = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = b[i];
            repeat (DIV) @(negedge clk);
        end
        uart_rxd = stopBit;
        for (int c = 0; c < DIV; c++) begin
            if (rdAtStop) begin
                if (c == PUSH_EDGE - 1 - 9 * DIV) begin
                    bus.rd   = 1'b1;
                    bus.addr = 2'd0;
                    postPin(0, popExp, "data_pop_at_push");
                end else begin
                    bus.rd = 1'b0;
                end
            end
            @(negedge clk);
        end
        bus.rd = 1'b0;
    endtask

    task automatic applyStimulus();
        // Reset
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;

        // Single byte
        busWrite(2'd2, 32'h1);
        sendFrame(8'hA5, 1'b1, 1'b0, 32'h0);
        expectIrq(1'b1, "irq_single");
        busRead(2'd1, 32'h0000_0100, "status_single");
        busRead(2'd0, 32'h0000_00A5, "data_single");
        expectIrq(1'b0, "irq_after_pop");

        // Overrun and wrap
        for (int i = 1; i <= 5; i++) begin
            sendFrame(8'(i), 1'b1, 1'b0, 32'h0);
        end
        busRead(2'd1, 32'h0000_040A, "status_overrun");
        for (int i = 1; i <= 4; i++) begin
            busRead(2'd0, 32'(i), $sformatf("data_wrap_%0d", i));
        end
        busRead(2'd0, 32'h0, "data_empty");
        busWrite(2'd1, 32'h8);
        busRead(2'd1, 32'h0000_0001, "status_ovr_cleared");

        // Framing error and break
        sendFrame(8'h3C, 1'b0, 1'b0, 32'h0);
        repeat (40) @(negedge clk);
        uart_rxd = 1'b1;
        repeat (8) @(negedge clk);
        busRead(2'd1, 32'h0000_0005, "status_ferr");
        busWrite(2'd1, 32'h4);
        sendFrame(8'h55, 1'b1, 1'b0, 32'h0);
        busRead(2'd1, 32'h0000_0100, "status_after_break");
        busRead(2'd0, 32'h0000_0055, "data_after_break");

        // Glitch rejection
        @(negedge clk);
        uart_rxd = 1'b0;
        repeat (3) @(negedge clk);
        uart_rxd = 1'b1;
        repeat (30) @(negedge clk);
        busRead(2'd1, 32'h0000_0001, "status_glitch");

        // Simultaneous push and pop while full
        sendFrame(8'h11, 1'b1, 1'b0, 32'h0);
        sendFrame(8'h22, 1'b1, 1'b0, 32'h0);
        sendFrame(8'h33, 1'b1, 1'b0, 32'h0);
        sendFrame(8'h44, 1'b1, 1'b0, 32'h0);
        sendFrame(8'h99, 1'b1, 1'b1, 32'h0000_0011);
        busRead(2'd1, 32'h0000_0402, "status_push_pop");
        busRead(2'd0, 32'h0000_0022, "data_pp_1");
        busRead(2'd0, 32'h0000_0033, "data_pp_2");
        busRead(2'd0, 32'h0000_0044, "data_pp_3");
        busRead(2'd0, 32'h0000_0099, "data_pp_4");

        // Mid-frame reset during bit 4, with irq high and rdata nonzero
        sendFrame(8'h42, 1'b1, 1'b0, 32'h0);
        expectIrq(1'b1, "irq_before_reset");
        @(negedge clk);
        pendByte = 8'hC3;
        pendStop = 1'b1;
        frameSeq++;
        uart_rxd = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            uart_rxd = pendByte[i];
            repeat (DIV) @(negedge clk);
        end
        uart_rxd = pendByte[4];
        repeat (DIV / 2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        uart_rxd = 1'b1;
        reset    = 1'b1;
        repeat (20) @(negedge clk);
        busRead(2'd2, 32'h0, "ctrl_after_reset");
        busWrite(2'd2, 32'h1);
        sendFrame(8'h7E, 1'b1, 1'b0, 32'h0);
        expectIrq(1'b1, "irq_after_reset_frame");
        busRead(2'd1, 32'h0000_0100, "status_after_reset");
        busRead(2'd0, 32'h0000_007E, "data_after_reset");
        repeat (5) @(negedge clk);
    endtask

    initial begin
        bus.rd    = 1'b0;
        bus.we    = 1'b0;
        bus.addr  = 2'd0;
        bus.wdata = 32'h0;
        $display("[TB] starting uart_rx_fifo directed test");
        applyStimulus();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
